// File: rtl/data_port_arbiter_pkg.sv
// Shared definitions for the main-memory data port arbiter.
//   REQ_CPU / REQ_DMA : owner encodings carried through the read tag pipeline
//   DEF_ADDR_W/DEF_DATA_W : default data-port address and data widths
//   WAIT_W            : width of the DMA starvation counter
//   rd_tag_t          : one in-flight read tag {valid, owner}
package data_port_arbiter_pkg;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int unsigned DEF_ADDR_W = 14;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned WAIT_W     = 4;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/data_port_arbiter_rd_tag_pipe.sv
// Read tag pipeline: a DEPTH-deep shift register of {valid, owner} tags that
// follows each granted read through the RAM's fixed read latency.
//   clk, reset           : system clock, asynchronous active-high reset
//   in_valid, in_owner   : tag loaded into stage 0 every cycle
//   out_valid, out_owner : tag at the last stage (DEPTH cycles after loading)
module data_port_arbiter_rd_tag_pipe
  import data_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  rd_tag_t               tag_in;
  rd_tag_t [DEPTH-1:0]   stage_q;

  assign tag_in = '{valid: in_valid, owner: in_owner};

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= tag_in;
      end
    end
  end else begin : g_shift
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[DEPTH-2:0], tag_in};
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_owner = stage_q[DEPTH-1].owner;

endmodule

// File: rtl/data_port_arbiter.sv
// Main-memory data port arbiter between the CPU memory controller and the
// DMA / draw-list fetch engine.
//   clk, reset                    : system clock, async active-high reset
//   cpu_req/we/addr/wdata -> gnt  : CPU request, granted combinationally
//   cpu_rvalid, cpu_rdata         : CPU read return
//   dma_req/we/addr/wdata -> gnt  : DMA request, granted combinationally
//   dma_rvalid, dma_rdata         : DMA read return
//   mem_addr/we/wdata, mem_rdata  : RAM data port (rdata RD_LAT cycles later)
// The CPU has fixed priority; after MAX_WAIT consecutive denied cycles the DMA
// is forced through for one grant.
module data_port_arbiter
  import data_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [WAIT_W-1:0] MaxWaitC = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              force_dma;
  logic              rd_issue;
  logic              rd_owner;
  logic              ret_valid;
  logic              ret_owner;
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

  // Grant and memory-side steering. Grants are masked during reset so the
  // port is quiet while reset is held.
  always_comb begin
    force_dma = (wait_cnt_q == MaxWaitC);
    cpu_gnt   = cpu_req & ~force_dma & ~reset;
    dma_gnt   = dma_req & (~cpu_req | force_dma) & ~reset;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_issue  = 1'b0;
    rd_owner  = REQ_CPU;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      rd_issue  = ~cpu_we;
      rd_owner  = REQ_CPU;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      rd_issue  = ~dma_we;
      rd_owner  = REQ_DMA;
    end
  end

  // Counts consecutive denied DMA cycles, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_d = '0;
    if (dma_req && !dma_gnt) begin
      wait_cnt_d = (wait_cnt_q == MaxWaitC) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  data_port_arbiter_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_issue),
    .in_owner  (rd_owner),
    .out_valid (ret_valid),
    .out_owner (ret_owner)
  );

  assign cpu_rvalid = ret_valid & (ret_owner == REQ_CPU);
  assign dma_rvalid = ret_valid & (ret_owner == REQ_DMA);

  // RAM data is only valid in the return cycle, so it is passed straight
  // through then and captured for the owner to hold until its next read.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dma_rvalid) dma_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// Self-checking bench for data_port_arbiter: directed scenarios followed by
// randomized requesters, all compared against a transaction-level model.
module tb_data_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 16;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;
  localparam int MEM_N    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;

  always #5 clk = ~clk;

  data_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_LAT   (RD_LAT),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'(a * 40503) ^ 16'h1234;
  endfunction

  // Read-first synchronous RAM with RD_LAT cycles of read latency.
  logic [DATA_W-1:0] ram [MEM_N];
  logic [DATA_W-1:0] rd_line [RD_LAT];
  logic              ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < MEM_N; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rd_line[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_line[i] <= rd_line[i-1];
  end

  assign mem_rdata = rd_line[RD_LAT-1];

  // Transaction-level model: memory image, queue of outstanding reads with
  // their due cycle, denied-cycle count and last data seen per requester.
  typedef struct {
    int                cyc_due;
    logic              owner;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic [DATA_W-1:0] model_mem [MEM_N];
  rd_t               pend_q[$];
  int                cyc;
  int                m_wait;
  logic [DATA_W-1:0] m_last [2];
  logic              exp_cg, exp_dg;
  logic              got_dg;
  int                n_total, n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_access(input logic owner, input logic we, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    rd_t r;
    if (we) begin
      model_mem[a] = d;
    end else begin
      r.cyc_due = cyc + RD_LAT;
      r.owner   = owner;
      r.data    = model_mem[a];
      pend_q.push_back(r);
    end
  endtask

  // One clock cycle: drive requests, check all outputs, advance the model.
  task automatic step(input logic cr, input logic cw, input logic [ADDR_W-1:0] ca,
                      input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                      input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
    logic              frc, ev, ewe, erv_c, erv_d;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ewd, erd_c, erd_d;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    frc    = (m_wait == MAX_WAIT);
    exp_cg = cr && !frc;
    exp_dg = dr && (!cr || frc);
    ewe = 1'b0; ea = '0; ewd = '0;
    if (exp_cg) begin
      ewe = cw; ea = ca; ewd = cd;
    end else if (exp_dg) begin
      ewe = dw; ea = da; ewd = dd;
    end
    ev    = (pend_q.size() > 0) && (pend_q[0].cyc_due == cyc);
    erv_c = ev && (pend_q[0].owner == 1'b0);
    erv_d = ev && (pend_q[0].owner == 1'b1);
    erd_c = erv_c ? pend_q[0].data : m_last[0];
    erd_d = erv_d ? pend_q[0].data : m_last[1];
    got_dg = dma_gnt;
    check_eq("cpu_gnt", cpu_gnt, exp_cg);
    check_eq("dma_gnt", dma_gnt, exp_dg);
    check_eq("mem_we", mem_we, ewe);
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_wdata", mem_wdata, ewd);
    check_eq("cpu_rvalid", cpu_rvalid, erv_c);
    check_eq("dma_rvalid", dma_rvalid, erv_d);
    check_eq("cpu_rdata", cpu_rdata, erd_c);
    check_eq("dma_rdata", dma_rdata, erd_d);
    @(posedge clk);
    if (ev) begin
      m_last[pend_q[0].owner] = pend_q[0].data;
      void'(pend_q.pop_front());
    end
    if (exp_cg) model_access(1'b0, cw, ca, cd);
    if (exp_dg) model_access(1'b1, dw, da, dd);
    m_wait = (dr && !exp_dg) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Asserts reset mid-cycle with both requesters active; everything must go quiet.
  task automatic apply_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0155; cpu_wdata = 16'hA5A5;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 14'h02AA; dma_wdata = 16'h5A5A;
    reset = 1'b1;
    #1;
    check_eq("rst_cpu_gnt", cpu_gnt, 1'b0);
    check_eq("rst_dma_gnt", dma_gnt, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, '0);
    check_eq("rst_mem_wdata", mem_wdata, '0);
    check_eq("rst_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
    check_eq("rst_cpu_rdata", cpu_rdata, '0);
    check_eq("rst_dma_rdata", dma_rdata, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hold_gnt", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}, 4'b0000);
    reset   = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    pend_q.delete();
    m_wait    = 0;
    m_last[0] = '0;
    m_last[1] = '0;
  endtask

  logic              c_p, c_w, d_p, d_w;
  logic [ADDR_W-1:0] c_a, d_a;
  logic [DATA_W-1:0] c_d, d_d;
  int                dma_wins;

  initial begin
    n_total = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < MEM_N; i++) model_mem[i] = pat(i);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    reset = 1'b1;
    @(negedge clk);
    apply_reset();

    // Idle port.
    idle(2);

    // CPU write then read-back of the same word.
    step(1'b1, 1'b1, 14'h0010, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b0, '0, '0);
    idle(RD_LAT + 1);

    // Continuous contention: DMA wins one of every MAX_WAIT+1 cycles.
    dma_wins = 0;
    for (int i = 0; i < 2 * (MAX_WAIT + 1); i++) begin
      step(1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, 1'b0, ADDR_W'(16 + i), '0);
      if (got_dg) dma_wins++;
    end
    check_eq("contention_dma_share", dma_wins, 2);
    idle(RD_LAT + 1);

    // Alternating owners, back-to-back reads.
    step(1'b1, 1'b0, 14'h0001, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h0002, '0);
    step(1'b1, 1'b0, 14'h0003, '0, 1'b0, 1'b0, '0, '0);
    idle(RD_LAT + 2);

    // DMA alone is always granted at once.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'(i & 1), ADDR_W'(32 + i), DATA_W'(16'h7000 + i));
    end
    idle(RD_LAT + 1);

    // Write right after a read to the same address returns the old word.
    step(1'b1, 1'b0, 14'h0020, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'h0020, 16'hC0DE);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h0020, '0);
    idle(RD_LAT + 1);

    // Reset one cycle after a CPU read grant discards that read.
    step(1'b1, 1'b0, 14'h0010, '0, 1'b0, 1'b0, '0, '0);
    apply_reset();
    idle(RD_LAT + 2);

    // Randomized requesters that hold their request until granted.
    c_p = 1'b0; d_p = 1'b0;
    c_w = 1'b0; d_w = 1'b0; c_a = '0; d_a = '0; c_d = '0; d_d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_p && $urandom_range(0, 99) < 70) begin
        c_p = 1'b1;
        c_w = 1'($urandom_range(0, 1));
        c_a = ADDR_W'($urandom_range(0, 31));
        c_d = DATA_W'($urandom);
      end
      if (!d_p && $urandom_range(0, 99) < 50) begin
        d_p = 1'b1;
        d_w = 1'($urandom_range(0, 1));
        d_a = ADDR_W'($urandom_range(0, 31));
        d_d = DATA_W'($urandom);
      end
      step(c_p, c_w, c_a, c_d, d_p, d_w, d_a, d_d);
      if (exp_cg) c_p = 1'b0;
      if (exp_dg) d_p = 1'b0;
      if (i == 1500) apply_reset();
    end
    idle(RD_LAT + 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/data_port_arbiter.md
Name: data_port_arbiter

Overview:
- Shares the single main-memory data port (addr/wdata/we in, rdata out) between two requesters: the CPU memory controller (req 0) and a DMA/draw-list fetch engine (req 1).
- Fixed priority goes to the CPU, with a starvation guard that forces a DMA grant after MAX_WAIT lost cycles.
- Tracks in-flight reads through the RAM's fixed read latency and steers rdata and rvalid back to the requester that issued each read.
- Sits between the memory controller / DMA engine and the main memory, clocked on the 25 MHz system clock.

Parameters:
ADDR_W, 14, data-port address width
DATA_W, 16, data word width
RD_LAT, 1, main-memory read latency in cycles (1..4)
MAX_WAIT, 4, consecutive cycles DMA may be denied before it is forced (1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, valid this cycle
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_W  CPU read data
dma_req  in  1  DMA access request
dma_we  in  1  DMA write / read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA write data
dma_gnt  out  1  DMA access accepted this cycle
dma_rvalid  out  1  DMA read data valid
dma_rdata  out  DATA_W  DMA read data
mem_addr  out  ADDR_W  to RAM data port
mem_we  out  1  to RAM write enable
mem_wdata  out  DATA_W  to RAM write data
mem_rdata  in  DATA_W  from RAM, valid RD_LAT cycles after address

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted and on release: all gnt, rvalid and mem_we are 0; mem_addr, mem_wdata, rdata outputs and wait_cnt are 0; the tag pipeline is cleared.
- Grant is combinational in the request cycle.
  - The CPU is granted when cpu_req=1 and force=0.
  - The DMA is granted when dma_req=1 and (cpu_req=0 or force=1).
  - force = (wait_cnt == MAX_WAIT).
  - cpu_gnt and dma_gnt are never both 1.
- A requester holds req, we, addr and wdata stable until it sees gnt. A request is consumed in the cycle gnt=1.
- Memory side is combinational from the granted requester.
  - mem_we = granted & we.
  - When neither side is granted, mem_we=0 and addr/wdata are 0.
- wait_cnt (4 bit):
  - Increments when dma_req=1 and dma_gnt=0.
  - Clears on dma_gnt or dma_req=0.
  - Saturates at MAX_WAIT.
- Read tracking: a shift register RD_LAT deep holding {valid, owner}.
  - Stage 0 loads valid = (granted & ~we) and owner = (1 for DMA).
  - At the last stage, if valid: the owner's rvalid=1 and its rdata=mem_rdata, registered per requester. The other requester's rvalid=0 and its rdata holds its last value.
  - Read-to-rvalid latency is exactly RD_LAT cycles from the gnt cycle.
  - Back-to-back reads from alternating owners return in issue order, one per cycle, with no bubbles.
- Write-after-read to the same address in consecutive cycles is legal. The read returns old data, as in RAM read-first mode.
- Reset mid-flight: in-flight reads are discarded and no rvalid is produced after reset.
- No FIFO and no combinational path from mem_rdata to gnt.

Decomposition:
- Shared package holds REQ_CPU=0 and REQ_DMA=1 owner encodings and the default ADDR_W/DATA_W.
- One natural sub-module: rd_tag_pipe (RD_LAT-deep valid/owner shift register with async reset).
- Grant logic and wait_cnt stay in the top module.

Test Plan:
- CPU only, RD_LAT=1:
  - Write 0xBEEF to 0x0010 -> mem_we=1, mem_addr=0x0010 in the gnt cycle.
  - Then read 0x0010 -> cpu_rvalid=1, cpu_rdata=0xBEEF one cycle later; dma_rvalid stays 0.
- Contention, MAX_WAIT=4:
  - Hold cpu_req=1 and dma_req=1 continuously -> cpu_gnt for 4 cycles, dma_gnt on the 5th, wait_cnt back to 0.
  - The pattern repeats, so DMA gets 1 of every 5 cycles.
- Alternating reads, RD_LAT=2:
  - CPU reads 0x0001, DMA reads 0x0002, CPU reads 0x0003 in consecutive cycles (DMA granted while cpu_req=0).
  - Required response: rvalid pulses cpu, dma, cpu on cycles +2, +3, +4 with the matching data.
- DMA only, no CPU: every dma_req is granted in the same cycle and wait_cnt stays 0.
- Reset mid-read, RD_LAT=3:
  - Assert reset one cycle after a CPU read gnt -> no cpu_rvalid is ever produced for that read.
  - All outputs are 0 during reset.
- Idle: cpu_req=dma_req=0 -> both gnt=0, mem_we=0, mem_addr=0.
